// File: rtl/robber_pkg.sv
// Shared constants for the robber-language core and its output stage.
package robber_pkg;

  localparam int BYTE_W  = 8;
  localparam int COUNT_W = 16;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 16'hFFFF;
  localparam logic [BYTE_W-1:0]  CHAR_O    = 8'h6F;

  // Counter increment that parks at COUNT_MAX instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    if (v == COUNT_MAX) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/robber_fifo_ram.sv
// Register-array byte storage: one write port, one asynchronous read port.
// Entry 0 is cleared on reset so the head byte reads as zero afterwards.
module robber_fifo_ram
  import robber_pkg::*;
#(
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic                 i_wr_en,
  input  logic [ADDR_BITS-1:0] i_wr_addr,
  input  logic [BYTE_W-1:0]    i_wr_data,
  input  logic [ADDR_BITS-1:0] i_rd_addr,
  output logic [BYTE_W-1:0]    o_rd_data
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [BYTE_W-1:0] r_mem [DEPTH];

  // Storage write; only entry 0 has a defined reset value.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_mem[0] <= 8'h00;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end else begin
      r_mem[0] <= r_mem[0];
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/robber_output_fifo.sv
// Show-ahead output FIFO behind the robber core: buffers encode bursts,
// presents them on ready/valid, and reports fill, sticky overflow and a byte count.
module robber_output_fifo
  import robber_pkg::*;
#(
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic [BYTE_W-1:0]    in_data,
  input  logic                 in_valid,
  input  logic                 flush,
  output logic [BYTE_W-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_BITS:0]   fill_level,
  output logic                 overflow,
  output logic [COUNT_W-1:0]   byte_count
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0]   FULL_LVL = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   FILL_ONE = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);

  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [ADDR_BITS:0]   r_fill;
  logic                 r_overflow;
  logic [COUNT_W-1:0]   r_byte_count;
  logic                 w_rd;
  logic                 w_wr;

  // A read frees a slot in the same edge, so a full FIFO can still accept a byte.
  always_comb begin
    w_rd = 1'b0;
    w_wr = 1'b0;
    if (flush) begin
      w_rd = 1'b0;
      w_wr = 1'b0;
    end else begin
      w_rd = (r_fill != {(ADDR_BITS + 1){1'b0}}) && out_ready;
      w_wr = in_valid && ((r_fill < FULL_LVL) || w_rd);
    end
  end

  // Pointer, fill, overflow and counter state; flush clears like reset except memory.
  always_ff @(posedge clk) begin
    if (!reset_l || flush) begin
      r_wr_ptr     <= {ADDR_BITS{1'b0}};
      r_rd_ptr     <= {ADDR_BITS{1'b0}};
      r_fill       <= {(ADDR_BITS + 1){1'b0}};
      r_overflow   <= 1'b0;
      r_byte_count <= 16'h0000;
    end else begin
      if (w_wr) begin
        r_wr_ptr     <= r_wr_ptr + PTR_ONE;
        r_byte_count <= sat_inc(r_byte_count);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_wr, w_rd})
        2'b10:   r_fill <= r_fill + FILL_ONE;
        2'b01:   r_fill <= r_fill - FILL_ONE;
        default: r_fill <= r_fill;
      endcase
      if (in_valid && !w_wr) begin
        r_overflow <= 1'b1;
      end
    end
  end

  robber_fifo_ram #(
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk       (clk),
    .reset_l   (reset_l),
    .i_wr_en   (w_wr),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (in_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (out_data)
  );

  assign out_valid  = (r_fill != {(ADDR_BITS + 1){1'b0}});
  assign fill_level = r_fill;
  assign overflow   = r_overflow;
  assign byte_count = r_byte_count;

endmodule

// File: tb/tb_robber_output_fifo.sv
// Scoreboard bench for robber_output_fifo: expected bytes queue up as they are
// driven and are compared as the consumer accepts them.
module tb_robber_output_fifo;
  import robber_pkg::*;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  fill_level;
  logic        overflow;
  logic [15:0] byte_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb[$];
  logic [7:0] last_pop = 8'h00;
  int pop_cnt = 0;

  robber_output_fifo #(.ADDR_BITS(4)) dut (
    .clk        (clk),
    .reset_l    (reset_l),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .flush      (flush),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fill_level (fill_level),
    .overflow   (overflow),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  // Scoreboard: inputs are stable at the negedge, so the next posedge's read/write is known here.
  always @(negedge clk) begin
    bit rd;
    bit wr;
    if (!reset_l || flush) begin
      sb.delete();
    end else begin
      n_checks++;
      if (out_valid !== (sb.size() != 0)) begin
        n_fail++;
        $display("FAIL out_valid_vs_model: got %b expected %b", out_valid, sb.size() != 0);
      end
      rd = (sb.size() != 0) && out_ready;
      wr = in_valid && ((sb.size() < 16) || rd);
      if (rd) begin
        n_checks++;
        if (out_data !== sb[0]) begin
          n_fail++;
          $display("FAIL data_order: got %h expected %h", out_data, sb[0]);
        end
        last_pop = sb.pop_front();
        pop_cnt++;
      end
      if (wr) sb.push_back(in_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic do_flush();
    idle();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
  endtask

  task automatic check_status(string name, logic [4:0] exp_fill, logic exp_ovf, logic [15:0] exp_cnt);
    n_checks++;
    if (fill_level !== exp_fill) begin
      n_fail++;
      $display("FAIL %s_fill: got %0d expected %0d", name, fill_level, exp_fill);
    end
    n_checks++;
    if (overflow !== exp_ovf) begin
      n_fail++;
      $display("FAIL %s_overflow: got %b expected %b", name, overflow, exp_ovf);
    end
    n_checks++;
    if (byte_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL %s_count: got %h expected %h", name, byte_count, exp_cnt);
    end
  endtask

  task automatic test_reset();
    idle();
    reset_l = 1'b0;
    cyc();
    cyc();
    check_status("reset", 5'd0, 1'b0, 16'h0000);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b data=%h expected 0/00", out_valid, out_data);
    end
    reset_l = 1'b1;
    cyc();
  endtask

  task automatic test_burst();
    logic [7:0] word [3];
    int peak;
    word[0] = 8'h62; word[1] = CHAR_O; word[2] = 8'h62;
    peak = 0;
    do_flush();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = word[i];
      cyc();
      if (int'(fill_level) > peak) peak = int'(fill_level);
      if (i == 0) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h62) begin
          n_fail++;
          $display("FAIL burst_first_visible: got valid=%b data=%h expected 1/62", out_valid, out_data);
        end
      end
    end
    in_valid = 1'b0;
    cyc();
    n_checks++;
    if (peak != 1) begin
      n_fail++;
      $display("FAIL burst_peak_fill: got %0d expected 1", peak);
    end
    check_status("burst", 5'd0, 1'b0, 16'd3);
    idle();
  endtask

  task automatic test_overflow();
    do_flush();
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      cyc();
      if (i == 15) check_status("ovf_at16", 5'd16, 1'b0, 16'd16);
    end
    in_valid = 1'b0;
    check_status("ovf_full", 5'd16, 1'b1, 16'd16);
    out_ready = 1'b1;
    pop_cnt = 0;
    for (int i = 0; i < 18; i++) cyc();
    check_status("ovf_drained", 5'd0, 1'b1, 16'd16);
    n_checks++;
    if (pop_cnt != 16 || last_pop !== 8'h0F) begin
      n_fail++;
      $display("FAIL ovf_drain_count: got %0d last=%h expected 16 last=0f", pop_cnt, last_pop);
    end
    idle();
  endtask

  task automatic test_full_rw();
    do_flush();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h20 + 8'(i);
      cyc();
    end
    in_data   = 8'hAA;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    check_status("full_rw", 5'd16, 1'b0, 16'd17);
    pop_cnt = 0;
    for (int i = 0; i < 17; i++) cyc();
    n_checks++;
    if (pop_cnt != 16 || last_pop !== 8'hAA || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_rw_last: got pops=%0d last=%h valid=%b expected 16/aa/0", pop_cnt, last_pop, out_valid);
    end
    idle();
  endtask

  task automatic test_wrap();
    int pushed;
    int max_fill;
    int j;
    pushed = 0; max_fill = 0; j = 0;
    do_flush();
    pop_cnt = 0;
    while (pushed < 40) begin
      in_valid  = (j % 3) != 2;
      in_data   = 8'(pushed * 7 + 3);
      out_ready = (j % 2) == 1;
      cyc();
      if (in_valid) pushed++;
      if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
      j++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    n_checks++;
    if (pop_cnt != 40 || max_fill > 16 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap: got pops=%0d max_fill=%0d ovf=%b expected 40/<=16/0", pop_cnt, max_fill, overflow);
    end
    n_checks++;
    if (last_pop !== 8'(39 * 7 + 3)) begin
      n_fail++;
      $display("FAIL wrap_last: got %h expected %h", last_pop, 8'(39 * 7 + 3));
    end
    idle();
  endtask

  task automatic test_flush();
    do_flush();
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h40 + 8'(i);
      cyc();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) cyc();
    out_ready = 1'b0;
    check_status("pre_flush", 5'd5, 1'b1, 16'd16);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    out_ready = 1'b1;
    cyc();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_status("flush", 5'd0, 1'b0, 16'd0);
    pop_cnt = 0;
    for (int i = 0; i < 4; i++) cyc();
    n_checks++;
    if (out_valid !== 1'b0 || pop_cnt != 0) begin
      n_fail++;
      $display("FAIL flush_no_55: got valid=%b pops=%0d expected 0/0", out_valid, pop_cnt);
    end
    idle();
  endtask

  task automatic test_reset_burst();
    do_flush();
    in_valid = 1'b1;
    in_data  = 8'h61;
    cyc();
    in_data  = 8'h62;
    cyc();
    reset_l  = 1'b0;
    in_data  = 8'h63;
    cyc();
    check_status("reset_burst", 5'd0, 1'b0, 16'd0);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_burst_out: got valid=%b data=%h expected 0/00", out_valid, out_data);
    end
    reset_l = 1'b1;
    in_data = 8'h64;
    cyc();
    in_valid = 1'b0;
    check_status("post_reset", 5'd1, 1'b0, 16'd1);
    n_checks++;
    if (out_data !== 8'h64) begin
      n_fail++;
      $display("FAIL post_reset_data: got %h expected 64", out_data);
    end
    out_ready = 1'b1;
    cyc();
    idle();
  endtask

  task automatic test_saturation();
    do_flush();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      in_data = 8'(i);
      cyc();
      if (i == 65533) check_status("sat_below", 5'd1, 1'b0, 16'hFFFE);
    end
    in_valid = 1'b0;
    cyc();
    check_status("sat", 5'd0, 1'b0, COUNT_MAX);
    idle();
  endtask

  initial begin
    test_reset();
    test_burst();
    test_overflow();
    test_full_rw();
    test_wrap();
    test_flush();
    test_reset_burst();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
